// File: rtl/snitch_icache_perf_counters.sv
// Saturating performance counters for the icache event outputs. Each fetch port
// contributes five event bits. The counters are read, or read and cleared,
// through a valid/ready request/response port with one response outstanding.
//
// Event vector layout per port (packed, MSB first, the same as icache_events_t):
//   [4] l0_miss, [3] l0_hit, [2] l0_prefetch, [1] l0_double_hit, [0] l0_stall
// Counter index = port*5 + e, where e=0 is l0_miss and e=4 is l0_stall.
module snitch_icache_perf_counters #(
  parameter int unsigned NR_FETCH_PORTS = 1,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH     =
      (NR_FETCH_PORTS * 5 > 1) ? $clog2(NR_FETCH_PORTS * 5) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NR_FETCH_PORTS-1:0][4:0] events_i,
  input  logic                           enable_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [ADDR_WIDTH-1:0]          req_addr_i,
  input  logic                           req_clear_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [CNT_WIDTH-1:0]           rsp_data_o,
  output logic                           rsp_err_o
);

  localparam int unsigned NumCnt = NR_FETCH_PORTS * 5;

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] cnt_q [NumCnt];
  logic [CNT_WIDTH-1:0] cnt_d [NumCnt];
  logic [NumCnt-1:0]    ev;
  logic                 accept;
  logic                 in_range;
  logic [CNT_WIDTH-1:0] rd_data;

  assign rsp_valid_o = (state_q == StResp);
  assign req_ready_o = !rst_i && (!rsp_valid_o || rsp_ready_i);
  assign accept      = req_valid_i && req_ready_o;
  assign in_range    = (32'(req_addr_i) < NumCnt);

  // Flatten the per-port event structs into counter-index order.
  always_comb begin
    ev = '0;
    for (int unsigned p = 0; p < NR_FETCH_PORTS; p++) begin
      for (int unsigned e = 0; e < 5; e++) begin
        ev[p*5+e] = events_i[p][4-e];
      end
    end
  end

  // Select the addressed counter; out-of-range indices read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NumCnt; i++) begin
      if (32'(req_addr_i) == i) rd_data = cnt_q[i];
    end
  end

  // Next counter value: clear wins over saturation, and a same-cycle event survives a clear.
  always_comb begin
    for (int unsigned i = 0; i < NumCnt; i++) begin
      logic inc;
      logic clr;
      inc      = enable_i && ev[i];
      clr      = accept && in_range && req_clear_i && (32'(req_addr_i) == i);
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = inc ? CNT_WIDTH'(1) : '0;
      end else if (inc && (cnt_q[i] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumCnt; i++) begin
      if (rst_i) cnt_q[i] <= '0;
      else       cnt_q[i] <= cnt_d[i];
    end
  end

  // Response FSM with registered data and error outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rsp_data_o <= '0;
      rsp_err_o  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_q    <= StResp;
            rsp_data_o <= in_range ? rd_data : '0;
            rsp_err_o  <= !in_range;
          end
        end
        StResp: begin
          if (accept) begin
            rsp_data_o <= in_range ? rd_data : '0;
            rsp_err_o  <= !in_range;
          end else if (rsp_ready_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_snitch_icache_perf_counters.sv
// Scoreboard bench: the driver pushes the hand-computed response for each
// accepted request, and a monitor pops it when the DUT presents a response.
module tb_snitch_icache_perf_counters;

  localparam int unsigned NP = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned AW = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NP-1:0][4:0]     events;
  logic                   enable;
  logic                   req_valid;
  logic                   req_ready;
  logic [AW-1:0]          req_addr;
  logic                   req_clear;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [CW-1:0]          rsp_data;
  logic                   rsp_err;

  typedef struct packed {
    logic [CW-1:0] data;
    logic          err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [4:0] EvMiss = 5'b10000;
  localparam logic [4:0] EvHit  = 5'b01000;
  localparam logic [4:0] EvPref = 5'b00100;
  localparam logic [4:0] EvStal = 5'b00001;

  always #5 clk = ~clk;

  snitch_icache_perf_counters #(
    .NR_FETCH_PORTS(NP),
    .CNT_WIDTH     (CW),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .events_i   (events),
    .enable_i   (enable),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_clear_i(req_clear),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int port, input logic [4:0] mask, input int n, input logic en);
    events[port] = mask;
    enable       = en;
    tick(n);
    events = '0;
    enable = 1'b0;
  endtask

  // Issue one request and record its expected response on acceptance.
  task automatic req(input int a, input logic clr, input logic [CW-1:0] d, input logic e);
    int w = 0;
    req_valid = 1'b1;
    req_addr  = AW'(a);
    req_clear = clr;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_accept_timeout: addr %0d not accepted, expected acceptance", a);
    end else begin
      exp_q.push_back('{data: d, err: e});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_clear = 1'b0;
    events    = '0;
    enable    = 1'b0;
  endtask

  // Monitor: compare each consumed response against the scoreboard head.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got data %0d, expected no response", rsp_data);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(rsp_data), 64'(e.data));
          check("rsp_err", 64'(rsp_err), 64'(e.err));
        end
      end
    end
  end

  initial begin
    logic [CW-1:0] exp_all [10];
    rst       = 1'b1;
    events    = '0;
    enable    = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_clear = 1'b0;
    rsp_ready = 1'b1;

    // Events during reset must not count.
    events[0] = 5'b11111;
    events[1] = 5'b11111;
    enable    = 1'b1;
    tick(2);
    @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'(0));
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_data", 64'(rsp_data), 64'(0));
    check("reset_rsp_err", 64'(rsp_err), 64'(0));
    @(posedge clk);
    #1;
    rst    = 1'b0;
    events = '0;
    enable = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 64'(req_ready), 64'(1));
    @(posedge clk);
    #1;

    // Seven l0_hit pulses on port 0.
    pulse(0, EvHit, 7, 1'b1);
    req(1, 1'b0, 4'd7, 1'b0);
    req(0, 1'b0, 4'd0, 1'b0);

    // Port 1 miss+stall: three enabled cycles, two disabled.
    pulse(1, EvMiss | EvStal, 3, 1'b1);
    pulse(1, EvMiss | EvStal, 2, 1'b0);
    exp_all = '{4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd3};
    for (int i = 0; i < 10; i++) req(i, 1'b0, exp_all[i], 1'b0);

    // Saturation: 20 prefetch pulses into a 4-bit counter.
    pulse(0, EvPref, 20, 1'b1);
    req(2, 1'b0, 4'd15, 1'b0);

    // Bring idx 1 to 10, then read-and-clear with a same-cycle hit.
    pulse(0, EvHit, 3, 1'b1);
    events[0] = EvHit;
    enable    = 1'b1;
    req(1, 1'b1, 4'd10, 1'b0);
    req(1, 1'b0, 4'd1, 1'b0);

    // Plain read-and-clear of idx 5.
    req(5, 1'b1, 4'd3, 1'b0);
    req(5, 1'b0, 4'd0, 1'b0);

    // Out-of-range clears: boundary index 10, then 13 and 15.
    req(10, 1'b1, 4'd0, 1'b1);
    req(13, 1'b1, 4'd0, 1'b1);
    req(15, 1'b1, 4'd0, 1'b1);
    exp_all = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
    for (int i = 0; i < 10; i++) req(i, 1'b0, exp_all[i], 1'b0);

    // Backpressure: let outstanding responses drain first.
    tick(2);
    rsp_ready = 1'b0;
    req(9, 1'b0, 4'd3, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'(1));
      check("hold_rsp_data", 64'(rsp_data), 64'(3));
      check("hold_req_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    #1;

    // Reset mid-hold drops the response; events during reset are ignored.
    rst = 1'b1;
    exp_q.delete();
    events[0] = EvHit;
    enable    = 1'b1;
    tick(1);
    @(negedge clk);
    check("rst_drop_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    events    = '0;
    enable    = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) req(i, 1'b0, 4'd0, 1'b0);

    tick(3);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snitch_icache_perf_counters.md
# snitch_icache_perf_counters

Performance-counter sink for the instruction cache's event outputs. It accumulates the per-fetch-port `icache_events_t` pulses (l0_miss, l0_hit, l0_prefetch, l0_double_hit, l0_stall) into saturating counters. The counters are exposed through a valid/ready read/clear port. The block sits beside the cluster icache and is read by the cluster peripheral register file.

## Interface
- `NR_FETCH_PORTS`, default 1: number of fetch ports; one event vector per port.
- `CNT_WIDTH`, default 32: counter width, 1..64.
- `ADDR_WIDTH`, default `$clog2(NR_FETCH_PORTS*5)`, minimum 1: counter index width.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `events_i`  in  `NR_FETCH_PORTS` x `icache_events_t`  single-cycle event pulses, one struct per port.
- `enable_i`  in  1  counting enable; when low, events are ignored.
- `req_valid_i`  in  1  access request valid.
- `req_ready_o`  out  1  access request accepted.
- `req_addr_i`  in  `ADDR_WIDTH`  counter index.
- `req_clear_i`  in  1  1 = read-and-clear, 0 = read.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_data_o`  out  `CNT_WIDTH`  counter value.
- `rsp_err_o`  out  1  index out of range.

## Operation
- Counter index: `idx = port*5 + e`.
  - e=0 l0_miss (struct MSB), 1 l0_hit, 2 l0_prefetch, 3 l0_double_hit, 4 l0_stall (struct LSB).
  - `NR_FETCH_PORTS*5` counters in total.
- Each cycle with `enable_i`=1, every set event bit increments its own counter by 1.
  - Events on different ports or bits in the same cycle are independent.
- Saturation: a counter at `2^CNT_WIDTH-1` stays there; it never wraps.
- Request accepted when `req_valid_i && req_ready_o`.
- `req_ready_o = !rst_i && (!rsp_valid_o || rsp_ready_i)`. At most one response is outstanding, and a new request may be accepted in the cycle the previous response is consumed.
- On acceptance with `idx < NR_FETCH_PORTS*5`:
  - `rsp_data_o` <= the counter value at the start of the accept cycle, excluding that cycle's increment.
  - `rsp_err_o` <= 0.
- On acceptance with `idx >= NR_FETCH_PORTS*5`:
  - `rsp_data_o` <= 0, `rsp_err_o` <= 1.
  - No counter changes, including when `req_clear_i`=1.
- Read-and-clear (`req_clear_i`=1, valid index): the counter is loaded with 0.
  - If its event fires in the same cycle with `enable_i`=1, it is loaded with 1 instead; no event is lost.
  - Clear takes priority over saturation.
- Response registers hold stable while `rsp_valid_o && !rsp_ready_i`.
- `rsp_valid_o` falls after `rsp_ready_i` unless a new request is accepted in the same cycle.
- Response state machine: IDLE (`rsp_valid_o`=0) -> RESP on accept. RESP -> IDLE on `rsp_ready_i` with no new accept. RESP -> RESP on `rsp_ready_i` with a new accept.
- Reset, when `rst_i`=1 at a rising edge:
  - All counters 0, `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_err_o`=0.
  - `req_ready_o`=0 while `rst_i` is high.
  - Reset mid-transaction drops the pending response, and events in the reset cycle are not counted.

## Timing
- Event-to-count latency is 1 cycle: a pulse in cycle n is visible to a read accepted in cycle n+1 or later.
- Request-to-response latency is 1 cycle: accept in cycle n gives `rsp_valid_o`=1 in n+1.
- Back-to-back throughput is 1 access per cycle when `rsp_ready_i` is held high.
- All outputs are registered except `req_ready_o`, which is combinational from `rsp_valid_o`, `rsp_ready_i` and `rst_i`.
- There is no combinational path from `events_i` or `req_*` to any `rsp_*` output.

## Test plan
- Reset, then 7 cycles of `events_i[0].l0_hit`=1 with `enable_i`=1, then read idx 1 -> `rsp_data_o`=7, `rsp_err_o`=0 one cycle after accept. A read of idx 0 returns 0.
- `NR_FETCH_PORTS`=2, with `l0_miss`+`l0_stall` on port 1 for 3 cycles and `enable_i`=0 for 2 further event cycles -> idx 5 = 3, idx 9 = 3, all other counters 0.
- `CNT_WIDTH`=4, 20 `l0_prefetch` pulses -> idx 2 reads 15 (saturated), not 4.
- Read-and-clear idx 1 while `l0_hit` fires in the same cycle, with the counter at 10 -> response data 10; an immediate re-read returns 1.
- Out-of-range index (5 with `NR_FETCH_PORTS`=1) with `req_clear_i`=1 -> `rsp_err_o`=1, `rsp_data_o`=0, and all counters unchanged.
- Backpressure with `rsp_ready_i`=0 for 4 cycles -> `rsp_valid_o`/`rsp_data_o` stable, `req_ready_o`=0. Asserting `rst_i` mid-hold drops the response, and all counters then read 0.
